sha1_block_sequencer: RTL
=========================

SHA1_BLOCK_SEQUENCER -- requirements
Module: sha1_block_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the memory word-address width in bits.
REQ-002 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-003 The block SHALL have port nreset, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to hash one message.
REQ-005 The block SHALL have port message_addr, input, 32, the byte address of the message; it is word aligned.
REQ-006 The block SHALL have port message_size, input, 32, the message length in bytes.
REQ-007 The block SHALL have the following memory ports:
- mem_addr, output, ADDR_W: the read address.
- mem_re, output, 1: the read strobe.
- mem_rdata, input, 32: the read data, valid 1 cycle after mem_re.
REQ-008 The block SHALL have the following round-core ports:
- w_data, output, 32: the schedule word.
- w_valid, output, 1: w_data is valid.
- w_ready, input, 1: the core accepts the word.
- w_first, output, 1: word 0 of the message.
- blk_last, output, 1: word 15 of a block.
REQ-009 The block SHALL have port core_blk_done, input, 1, a pulse from the core when its 80 rounds for the current block are complete.
REQ-010 The block SHALL have outputs busy (1) and done (1).

Function
REQ-011 Block count SHALL be nblk = floor((message_size+8)/64)+1, using 33-bit arithmetic.
REQ-012 Word i (0..16*nblk-1) covers bytes 4i..4i+3.
- Byte b < size: taken from memory.
- b == size: 0x80.
- Otherwise: 0x00.
- The final block's words 14/15 are {size,3'b000} as a 64-bit big-endian bit length; the upper 29 bits of word 14 are zero-extended.
REQ-013 Memory SHALL be read only for words with 4i < size, at address message_addr[ADDR_W-1:0] + 4i.
- Bytes at or beyond size within a read word SHALL be masked to pad values.
REQ-014 The states SHALL be IDLE, FETCH, WAIT, SEND, BLKWAIT, DONE.
REQ-015 IDLE: start SHALL latch addr and size, clear the word index, and go to FETCH; start while busy SHALL be ignored.
REQ-016 FETCH SHALL do one of the following:
- Word needs memory: assert mem_re for exactly 1 cycle, then go to WAIT.
- Otherwise: build the pad word and go to SEND.
REQ-017 WAIT SHALL capture mem_rdata into the word register and go to SEND.
REQ-018 SEND SHALL hold w_valid=1 and w_data stable until w_valid&&w_ready.
- On acceptance: increment the index.
- If the word was word 15 of its block, go to BLKWAIT; else go to FETCH.
REQ-019 BLKWAIT SHALL wait for core_blk_done.
- When it arrives, go to FETCH if blocks remain, else to DONE.
- core_blk_done outside BLKWAIT SHALL be ignored.
REQ-020 DONE SHALL pulse done for exactly 1 cycle, then return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 w_first and blk_last SHALL be valid only while w_valid=1.
REQ-023 Minimum latency SHALL be 3 cycles per memory word and 2 cycles per pad word when w_ready=1, plus the BLKWAIT time.
REQ-024 The index SHALL be 32 bits wide; address addition SHALL wrap modulo 2^ADDR_W.

Reset
REQ-025 nreset low SHALL asynchronously force IDLE and zero all of the following:
- mem_addr, mem_re
- w_data, w_valid, w_first, blk_last
- busy, done
- internal index, address and size registers
REQ-026 Reset mid-message SHALL abandon the message, issue no further reads, and require a new start.

Configuration
REQ-027 The block SHALL support macro SHA1_SEQ_ENDIAN_SWAP_EN.
- Defined: memory words SHALL be byte-reversed {d[7:0],d[15:8],d[23:16],d[31:24]} before masking/padding (little-endian memory).
- Undefined: mem_rdata SHALL be used unchanged as big-endian.

Verification
REQ-028 Scenario, macro defined: size=0 -> 1 block; w0=0x80000000, w1..w15=0; no mem_re; one done pulse.
REQ-029 Scenario, macro defined: size=3, mem word 0x00636261 -> w0=0x61626380, w1..w14=0, w15=0x00000018; exactly 1 mem_re.
REQ-030 Scenario: size=55 -> 1 block, w15=0x000001B8; size=56 -> 2 blocks, block 2 w15=0x000001C0, and BLKWAIT is held until core_blk_done.
REQ-031 Scenario: w_ready held low 5 cycles in SEND -> w_valid stays 1 and w_data stays unchanged; index advances once after w_ready rises.
REQ-032 Scenario: start pulsed while busy -> ignored; nreset asserted at word 7 -> all outputs 0 immediately; a new start with size=3 completes correctly.

Source files
------------

// File: rtl/sha1_block_sequencer.sv
// sha1_block_sequencer
// Reads a byte message from word-addressed memory and streams SHA-1 padded
// 32-bit schedule words (16 per 64-byte block) to a round core, waiting for
// the core to finish each block before sending the next.
// Build option: define SHA1_SEQ_ENDIAN_SWAP_EN when memory holds message bytes
// little-endian within each word; otherwise memory words are used as
// big-endian unchanged.

module sha1_block_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_first,
    output logic              blk_last,
    input  logic              core_blk_done,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        BLKWAIT,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       size_q;
    logic [31:0]       word_q;

    // Block count uses 33-bit arithmetic so sizes near 2^32 do not wrap;
    // last_blk is nblk-1, the index of the block carrying the bit length.
    logic [32:0]       size_plus8;
    logic [26:0]       last_blk;
    logic              final_blk;
    logic [33:0]       byte_base;
    logic [33:0]       size_ext;
    logic              need_mem;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       mem_word;
    logic [31:0]       raw_word;
    logic [31:0]       built_word;
    logic              unused_bits;

    assign size_plus8 = {1'b0, size_q} + 33'd8;
    assign last_blk   = size_plus8[32:6];
    assign final_blk  = (idx_q[31:4] == {1'b0, last_blk});
    assign byte_base  = {idx_q, 2'b00};
    assign size_ext   = {2'b00, size_q};
    assign need_mem   = (byte_base < size_ext);
    // Byte address of word idx; wraps modulo 2^ADDR_W by truncation.
    assign rd_addr    = addr_q + byte_base[ADDR_W-1:0];
    assign w_data     = word_q;

`ifdef SHA1_SEQ_ENDIAN_SWAP_EN
    assign mem_word = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};
`else
    assign mem_word = mem_rdata;
`endif

    // Pad words start from zero; only WAIT has real memory data to mask.
    assign raw_word = (state_q == WAIT) ? mem_word : 32'h0;

    // Upper address bits and the sub-block remainder are intentionally unused.
    assign unused_bits = ^{message_addr[31:ADDR_W], size_plus8[5:0]};

    // Word builder: keep message bytes, insert 0x80 at the end, zero the rest,
    // and overlay the 64-bit bit length on words 14/15 of the final block.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        built_word = '0;
        for (int k = 0; k < 4; k++) begin
            if ((byte_base + 34'(k)) < size_ext) begin
                built_word[31-8*k -: 8] = raw_word[31-8*k -: 8];
            end else if ((byte_base + 34'(k)) == size_ext) begin
                built_word[31-8*k -: 8] = 8'h80;
            end
        end
        if (final_blk && idx_q[3:0] == 4'd14) begin
            built_word = {29'd0, size_q[31:29]};
        end else if (final_blk && idx_q[3:0] == 4'd15) begin
            built_word = {size_q[28:0], 3'b000};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: message parameters, word index and the word buffer.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx_q  <= '0;
            addr_q <= '0;
            size_q <= '0;
            word_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= message_addr[ADDR_W-1:0];
                        size_q <= message_size;
                        idx_q  <= '0;
                    end
                end
                FETCH: begin
                    if (!need_mem) begin
                        word_q <= built_word;
                    end
                end
                WAIT: begin
                    word_q <= built_word;
                end
                SEND: begin
                    if (w_ready) begin
                        idx_q <= idx_q + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        mem_re   = 1'b0;
        mem_addr = '0;
        w_valid  = 1'b0;
        w_first  = 1'b0;
        blk_last = 1'b0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (need_mem) begin
                    mem_re   = 1'b1;
                    mem_addr = rd_addr;
                    state_d  = WAIT;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT: begin
                state_d = SEND;
            end
            SEND: begin
                w_valid  = 1'b1;
                w_first  = (idx_q == 32'd0);
                blk_last = (idx_q[3:0] == 4'hF);
                if (w_ready) begin
                    state_d = (idx_q[3:0] == 4'hF) ? BLKWAIT : FETCH;
                end
            end
            BLKWAIT: begin
                // idx already points at the next block here.
                if (core_blk_done) begin
                    state_d = (idx_q[31:4] <= {1'b0, last_blk}) ? FETCH : DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
